jtdd_obj_dma: RTL and testbench

// - Sequences the once-per-frame copy of object (sprite) attribute RAM into the object line-engine

---
 rtl/jtdd_obj_dma_if.sv | 25 ++
 rtl/jtdd_obj_dma.sv | 158 +++++++++++++++
 tb/tb_jtdd_obj_dma.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtdd_obj_dma_if.sv
// rtl/jtdd_obj_dma_if.sv - bus/handshake bundle between the object DMA and the shared RAMs
interface jtdd_obj_dma_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          busrq;
  logic          busak;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_din;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_dout;
  logic          dst_we;

  // DMA engine side
  modport master (
    output busrq, src_addr, dst_addr, dst_dout, dst_we,
    input  busak, src_din
  );

  // CPU bus arbiter / RAM side
  modport slave (
    input  busrq, src_addr, dst_addr, dst_dout, dst_we,
    output busak, src_din
  );
endinterface

// File: rtl/jtdd_obj_dma.sv
// rtl/jtdd_obj_dma.sv - once-per-frame object RAM copy sequencer; optional irq/irq_ack via JTDD_OBJDMA_IRQ_EN
module jtdd_obj_dma #(
  parameter int AW  = 9,
  parameter int DW  = 8,
  parameter int LEN = 512
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pxl_cen,
  input  logic           VBL,
  input  logic           trig,
  jtdd_obj_dma_if.master bus,
  output logic           busy,
  output logic           done
`ifdef JTDD_OBJDMA_IRQ_EN
  ,
  output logic           irq,
  input  logic           irq_ack
`endif
);

  // Counters carry one extra bit so a full 2**AW transfer ends without wrapping
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LEN_C  = CW'(LEN);
  localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COPY = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] rd_cnt, rd_nx;
  logic [CW-1:0] wr_cnt, wr_nx;
  logic          rd_vld, vld_nx;
  logic          armed, armed_nx;
  logic          vbl_last;
  logic          vbl_rise;

  logic          busrq_c;
  logic [AW-1:0] src_addr_c;
  logic [AW-1:0] dst_addr_c;
  logic [DW-1:0] dst_dout_c;
  logic          dst_we_c;

  assign vbl_rise = VBL & ~vbl_last;

  // State, counters and arming flag; everything except armed moves only on pxl_cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      rd_vld   <= 1'b0;
      armed    <= 1'b0;
      vbl_last <= 1'b0;
    end else begin
      armed <= armed_nx;
      if (pxl_cen) begin
        state    <= state_nx;
        rd_cnt   <= rd_nx;
        wr_cnt   <= wr_nx;
        rd_vld   <= vld_nx;
        vbl_last <= VBL;
      end
    end
  end

  // Next state, counter updates and bus outputs; write strobe and done are pxl_cen-wide
  always_comb begin
    state_nx   = state;
    rd_nx      = rd_cnt;
    wr_nx      = wr_cnt;
    vld_nx     = rd_vld;
    armed_nx   = armed;
    busrq_c    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    src_addr_c = '0;
    dst_addr_c = '0;
    dst_dout_c = '0;
    dst_we_c   = 1'b0;

    if (trig) armed_nx = 1'b1;

    case (state)
      IDLE: begin
        // trig arriving on the very clk of the edge counts as armed and is consumed here
        if (pxl_cen && vbl_rise && (armed || trig)) begin
          state_nx = REQ;
          armed_nx = 1'b0;
        end
      end

      REQ: begin
        busrq_c = 1'b1;
        busy    = 1'b1;
        if (pxl_cen && bus.busak) begin
          state_nx = COPY;
          rd_nx    = '0;
          wr_nx    = '0;
          vld_nx   = 1'b0;
        end
      end

      COPY: begin
        busrq_c    = 1'b1;
        busy       = 1'b1;
        src_addr_c = rd_cnt[AW-1:0];
        dst_addr_c = wr_cnt[AW-1:0];
        if (pxl_cen) begin
          if (bus.busak) begin
            // the read issued on the previous pxl_cen lands now
            if (rd_vld) begin
              dst_we_c   = 1'b1;
              dst_dout_c = bus.src_din;
              wr_nx      = wr_cnt + ONE_C;
              if (wr_cnt == LAST_C) begin
                done     = 1'b1;
                state_nx = IDLE;
              end
            end
            vld_nx = (rd_cnt < LEN_C);
            if (rd_cnt < LEN_C) rd_nx = rd_cnt + ONE_C;
          end else begin
            // bus taken back: drop the in-flight read and restart reading at the write pointer
            vld_nx = 1'b0;
            rd_nx  = wr_cnt;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.busrq    = busrq_c;
  assign bus.src_addr = src_addr_c;
  assign bus.dst_addr = dst_addr_c;
  assign bus.dst_dout = dst_dout_c;
  assign bus.dst_we   = dst_we_c;

`ifdef JTDD_OBJDMA_IRQ_EN
  // Sticky interrupt: set by done, cleared by an ack; set wins when both land together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (done) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_jtdd_obj_dma.sv
// tb/tb_jtdd_obj_dma.sv - scoreboard bench for jtdd_obj_dma
module tb_jtdd_obj_dma;
  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int LEN = 512;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pxl_cen = 1'b0;
  logic VBL = 1'b0;
  logic trig = 1'b0;
  logic busy, done;
`ifdef JTDD_OBJDMA_IRQ_EN
  logic irq;
  logic irq_ack = 1'b0;
`endif

  jtdd_obj_dma_if #(.AW(AW), .DW(DW)) bus ();

  jtdd_obj_dma #(.AW(AW), .DW(DW), .LEN(LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .VBL     (VBL),
    .trig    (trig),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
`ifdef JTDD_OBJDMA_IRQ_EN
    ,
    .irq     (irq),
    .irq_ack (irq_ack)
`endif
  );

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  int done_count = 0;
  int last_addr = -1;
  exp_t exp_q[$];
  logic [DW-1:0] src_mem [LEN];

  always #5 clk = ~clk;

  // pixel enable every other clk, changed just after the edge
  always @(posedge clk) #1 pxl_cen = ~pxl_cen;

  // source RAM: data follows the address one pxl_cen later
  always @(posedge clk) if (pxl_cen) bus.src_din <= src_mem[bus.src_addr];

  // destination monitor: pop the scoreboard on every write
  always @(negedge clk) begin
    if (bus.dst_we === 1'b1) begin
      exp_t e;
      we_count++;
      last_addr = int'(bus.dst_addr);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0h required=no write", bus.dst_addr, bus.dst_dout);
      end else begin
        e = exp_q.pop_front();
        if (bus.busak !== 1'b1 || bus.dst_addr !== e.addr || bus.dst_dout !== e.data) begin
          failures++;
          $display("FAIL dst_write addr=%0d data=%0h busak=%b required addr=%0d data=%0h busak=1",
                   bus.dst_addr, bus.dst_dout, bus.busak, e.addr, e.data);
        end
      end
    end
    if (done === 1'b1) done_count++;
  end

  task automatic next_cen();
    do begin
      @(posedge clk);
      #2;
    end while (pxl_cen !== 1'b1);
  endtask

  task automatic pulse_trig();
    @(posedge clk); #2 trig = 1'b1;
    @(posedge clk); #2 trig = 1'b0;
  endtask

  task automatic fill_and_expect();
    for (int k = 0; k < LEN; k++) src_mem[k] = DW'($urandom);
    for (int k = 0; k < LEN; k++) exp_q.push_back({AW'(k), src_mem[k]});
  endtask

  task automatic vbl_rise();
    VBL = 1'b0;
    next_cen();
    next_cen();
    VBL = 1'b1;
    next_cen();
  endtask

  task automatic wait_busrq(output bit ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.busrq === 1'b1) begin ok = 1; break; end
      next_cen();
    end
  endtask

  task automatic wait_writes(input int target, output bit ok);
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (we_count >= target) begin ok = 1; break; end
      next_cen();
    end
  endtask

  task automatic wait_idle(output int cens, output bit ok);
    ok = 0;
    cens = 0;
    for (int n = 1; n < 3000; n++) begin
      next_cen();
      if (busy === 1'b0) begin ok = 1; cens = n; break; end
    end
  endtask

  task automatic clear_frame();
    we_count = 0;
    done_count = 0;
    last_addr = -1;
  endtask

  task automatic test_reset();
    bus.busak = 1'b0;
    bus.src_din = '0;
    for (int k = 0; k < LEN; k++) src_mem[k] = '0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({bus.busrq, busy, done, bus.dst_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl busrq/busy/done/we=%b required 0000", {bus.busrq, busy, done, bus.dst_we});
    end
    checks++;
    if (bus.src_addr !== '0 || bus.dst_addr !== '0 || bus.dst_dout !== '0) begin
      failures++;
      $display("FAIL reset_bus src=%0d dst=%0d dout=%0h required 0 0 0", bus.src_addr, bus.dst_addr, bus.dst_dout);
    end
`ifdef JTDD_OBJDMA_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq irq=%b required 0", irq); end
`endif
    rst = 1'b0;
    next_cen();
  endtask

  task automatic test_no_arm();
    bit seen_rq = 0, seen_busy = 0;
    clear_frame();
    vbl_rise();
    for (int n = 0; n < 20; n++) begin
      if (bus.busrq === 1'b1) seen_rq = 1;
      if (busy === 1'b1) seen_busy = 1;
      next_cen();
    end
    checks++;
    if (seen_rq || seen_busy || we_count != 0) begin
      failures++;
      $display("FAIL no_arm busrq=%b busy=%b writes=%0d required 0 0 0", seen_rq, seen_busy, we_count);
    end
    VBL = 1'b0;
  endtask

  task automatic test_basic_copy();
    bit ok;
    int cens;
    clear_frame();
    pulse_trig();
    fill_and_expect();
    vbl_rise();
    wait_busrq(ok);
    checks++;
    if (!ok || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_request busrq=%b busy=%b required 1 1", bus.busrq, busy);
    end
    repeat (3) next_cen();
    checks++;
    if (we_count != 0 || bus.busrq !== 1'b1) begin
      failures++;
      $display("FAIL basic_grant_wait writes=%0d busrq=%b required 0 1", we_count, bus.busrq);
    end
    bus.busak = 1'b1;
    wait_idle(cens, ok);
    checks++;
    if (!ok || cens != LEN + 2) begin
      failures++;
      $display("FAIL basic_latency cens=%0d ok=%b required %0d", cens, ok, LEN + 2);
    end
    checks++;
    if (we_count != LEN || exp_q.size() != 0 || done_count != 1) begin
      failures++;
      $display("FAIL basic_totals writes=%0d left=%0d done=%0d required %0d 0 1", we_count, exp_q.size(), done_count, LEN);
    end
    checks++;
    if (last_addr != LEN - 1 || bus.busrq !== 1'b0) begin
      failures++;
      $display("FAIL basic_last last_addr=%0d busrq=%b required %0d 0", last_addr, bus.busrq, LEN - 1);
    end
`ifdef JTDD_OBJDMA_IRQ_EN
    repeat (3) next_cen();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set irq=%b required 1", irq); end
    irq_ack = 1'b1;
    @(posedge clk); #2 irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack irq=%b required 0", irq); end
`endif
    bus.busak = 1'b0;
    VBL = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_busak_drop();
    bit ok;
    int cens;
    clear_frame();
    pulse_trig();
    fill_and_expect();
    vbl_rise();
    wait_busrq(ok);
    bus.busak = 1'b1;
    wait_writes(100, ok);
    bus.busak = 1'b0;
    repeat (5) next_cen();
    checks++;
    if (!ok || we_count != 100) begin
      failures++;
      $display("FAIL drop_hold writes=%0d ok=%b required 100", we_count, ok);
    end
    checks++;
    if (bus.src_addr !== AW'(100)) begin
      failures++;
      $display("FAIL drop_reissue src_addr=%0d required 100", bus.src_addr);
    end
    bus.busak = 1'b1;
    wait_idle(cens, ok);
    checks++;
    if (!ok || we_count != LEN || exp_q.size() != 0 || done_count != 1) begin
      failures++;
      $display("FAIL drop_totals writes=%0d left=%0d done=%0d required %0d 0 1", we_count, exp_q.size(), done_count, LEN);
    end
    bus.busak = 1'b0;
    VBL = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok, seen_busy = 0;
    int cens;
    clear_frame();
    pulse_trig();
    fill_and_expect();
    vbl_rise();
    wait_busrq(ok);
    bus.busak = 1'b1;
    wait_writes(200, ok);
    pulse_trig();
    wait_idle(cens, ok);
    checks++;
    if (!ok || we_count != LEN || exp_q.size() != 0 || done_count != 1) begin
      failures++;
      $display("FAIL b2b_first writes=%0d left=%0d done=%0d required %0d 0 1", we_count, exp_q.size(), done_count, LEN);
    end
    for (int n = 0; n < 10; n++) begin
      if (busy === 1'b1) seen_busy = 1;
      next_cen();
    end
    checks++;
    if (seen_busy) begin
      failures++;
      $display("FAIL b2b_wait_edge busy=1 required 0 until next VBL rise");
    end
    clear_frame();
    fill_and_expect();
    vbl_rise();
    wait_busrq(ok);
    wait_idle(cens, ok);
    checks++;
    if (!ok || we_count != LEN || exp_q.size() != 0 || done_count != 1) begin
      failures++;
      $display("FAIL b2b_second writes=%0d left=%0d done=%0d required %0d 0 1", we_count, exp_q.size(), done_count, LEN);
    end
    bus.busak = 1'b0;
    VBL = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_copy();
    bit ok, seen_rq = 0;
    int cens;
    clear_frame();
    pulse_trig();
    fill_and_expect();
    vbl_rise();
    wait_busrq(ok);
    bus.busak = 1'b1;
    wait_writes(40, ok);
    pulse_trig();
    wait_writes(50, ok);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busrq, busy, bus.dst_we} !== 3'b000) begin
      failures++;
      $display("FAIL rst_async busrq/busy/we=%b required 000", {bus.busrq, busy, bus.dst_we});
    end
    exp_q.delete();
    bus.busak = 1'b0;
    VBL = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    clear_frame();
    vbl_rise();
    for (int n = 0; n < 10; n++) begin
      if (bus.busrq === 1'b1) seen_rq = 1;
      next_cen();
    end
    checks++;
    if (seen_rq || we_count != 0) begin
      failures++;
      $display("FAIL rst_disarm busrq=%b writes=%0d required 0 0", seen_rq, we_count);
    end
    clear_frame();
    pulse_trig();
    fill_and_expect();
    vbl_rise();
    wait_busrq(ok);
    bus.busak = 1'b1;
    wait_idle(cens, ok);
    checks++;
    if (!ok || we_count != LEN || exp_q.size() != 0 || done_count != 1 || last_addr != LEN - 1) begin
      failures++;
      $display("FAIL rst_recopy writes=%0d left=%0d done=%0d last=%0d required %0d 0 1 %0d",
               we_count, exp_q.size(), done_count, last_addr, LEN, LEN - 1);
    end
    bus.busak = 1'b0;
    VBL = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_no_arm();
    test_basic_copy();
    test_busak_drop();
    test_back_to_back();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
